// File: rtl/pico_fetch_exec_units_pkg.sv
// Shared constants, opcode codes, ALU function encoding and filter coefficients for the picoMIPS filter CPU.
package cpu_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int I_WIDTH      = 8;
    localparam int OPCODE_WIDTH = 2;
    localparam int IMM_WIDTH    = DATA_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] MUL = 2'b00;
    localparam logic [OPCODE_WIDTH-1:0] ADD = 2'b01;
    localparam logic [OPCODE_WIDTH-1:0] END = 2'b10;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_MUL   = 2'b01,
        ALU_PASSA = 2'b10,
        ALU_PASSB = 2'b11
    } aluFunc_t;

    // Q0.8 filter coefficients, indexed by the instruction imm field
    localparam logic [IMM_WIDTH-1:0] K [0:7] = '{
        8'd32, 8'd64, 8'd96, 8'd128, 8'd160, 8'd192, 8'd224, 8'd255
    };

endpackage

// File: rtl/pico_fetch_exec_units_alu.sv
// Unsigned datapath ALU: wrapping add, Q0.8 fractional multiply, operand pass-through.
// Purely combinational, zero latency.
module alu
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 8
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [1:0]            i_func,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int PW = 2*DATA_WIDTH + FRAC_BITS;

    // Extra headroom so an oversized FRAC_BITS shifts in zeros above the product
    logic [PW-1:0] w_prod;
    assign w_prod = PW'(i_a) * PW'(i_b);

    always_comb begin
        o_result = i_a;
        case (aluFunc_t'(i_func))
            ALU_ADD:   o_result = i_a + i_b;
            ALU_MUL:   o_result = DATA_WIDTH'(w_prod >> FRAC_BITS);
            ALU_PASSA: o_result = i_a;
            ALU_PASSB: o_result = i_b;
            default:   o_result = i_a;
        endcase
    end

endmodule

// File: rtl/pico_fetch_exec_units.sv
// Program counter, instruction field decoder and ALU of the picoMIPS filter CPU.
// PC updates on the rising clock edge; decoder and ALU are zero-latency combinational.
module pico_fetch_exec_units #(
    parameter int PC_WIDTH   = 6,
    parameter int I_WIDTH    = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pc_clr,
    input  logic                    pc_incr,
    output logic [PC_WIDTH-1:0]     pc,
    input  logic [I_WIDTH-1:0]      instr,
    output logic [1:0]              opcode,
    output logic signed [2:0]       offset,
    output logic [2:0]              imm,
    input  logic [DATA_WIDTH-1:0]   alu_a,
    input  logic [DATA_WIDTH-1:0]   alu_b,
    input  logic [1:0]              alu_func,
    output logic [DATA_WIDTH-1:0]   alu_result
);

    logic [PC_WIDTH-1:0] r_pc;

    // Clear beats increment; natural overflow gives the wrap to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
        end else if (pc_clr) begin
            r_pc <= '0;
        end else if (pc_incr) begin
            r_pc <= r_pc + PC_WIDTH'(1);
        end
    end

    assign pc = r_pc;

    assign opcode = instr[7:6];
    assign offset = instr[5:3];
    assign imm    = instr[2:0];

    alu #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_alu (
        .i_a      (alu_a),
        .i_b      (alu_b),
        .i_func   (alu_func),
        .o_result (alu_result)
    );

endmodule

// File: tb/tb_pico_fetch_exec_units.sv
// Randomized bench for pico_fetch_exec_units with an arithmetic reference model and directed literal checks.
module tb_pico_fetch_exec_units;

    logic       clk;
    logic       reset;
    logic       pc_clr;
    logic       pc_incr;
    logic [5:0] pc;
    logic [7:0] instr;
    logic [1:0] opcode;
    logic signed [2:0] offset;
    logic [2:0] imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_func;
    logic [7:0] alu_result;

    int n_total = 0;
    int n_pass  = 0;

    int exp_pc    = 0;
    bit exp_valid = 0;
    bit chk_en    = 0;

    pico_fetch_exec_units dut (
        .clk        (clk),
        .reset      (reset),
        .pc_clr     (pc_clr),
        .pc_incr    (pc_incr),
        .pc         (pc),
        .instr      (instr),
        .opcode     (opcode),
        .offset     (offset),
        .imm        (imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_func   (alu_func),
        .alu_result (alu_result)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int m_opcode(input int i); return (i / 64) % 4; endfunction
    function automatic int m_offset(input int i);
        int o;
        o = (i / 8) % 8;
        return (o > 3) ? o - 8 : o;
    endfunction
    function automatic int m_imm(input int i); return i % 8; endfunction
    function automatic int m_alu(input int f, input int a, input int b);
        case (f)
            0:       return (a + b) % 256;
            1:       return ((a * b) / 256) % 256;
            2:       return a;
            default: return b;
        endcase
    endfunction

    // Reference PC: counts edges with the priority reset > clear > increment
    always @(posedge clk) begin
        if (reset) begin
            exp_pc    <= 0;
            exp_valid <= 1;
        end else if (pc_clr) exp_pc <= 0;
        else if (pc_incr)    exp_pc <= (exp_pc + 1) % 64;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_valid) check("model_pc", int'(pc), exp_pc);
            check("model_opcode", int'(opcode), m_opcode(int'(instr)));
            check("model_offset", int'(offset), m_offset(int'(instr)));
            check("model_imm", int'(imm), m_imm(int'(instr)));
            check("model_alu", int'(alu_result), m_alu(int'(alu_func), int'(alu_a), int'(alu_b)));
        end
    end

    task automatic step(input logic r, input logic c, input logic i);
        reset = r; pc_clr = c; pc_incr = i;
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input string name, input logic [1:0] f, input logic [7:0] a,
                          input logic [7:0] b, input int exp);
        alu_func = f; alu_a = a; alu_b = b;
        #1;
        check(name, int'(alu_result), exp);
    endtask

    task automatic dec(input logic [7:0] ins, input int op, input int off, input int im);
        instr = ins;
        #1;
        check("dec_opcode", int'(opcode), op);
        check("dec_offset", int'(offset), off);
        check("dec_imm", int'(imm), im);
    endtask

    logic [7:0] p1, p2;

    initial begin
        reset = 1; pc_clr = 0; pc_incr = 0;
        instr = 0; alu_a = 0; alu_b = 0; alu_func = 0;
        chk_en = 1;

        step(1, 0, 1); check("reset_pc0", int'(pc), 0);
        step(1, 0, 1); check("reset_pc1", int'(pc), 0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 1);
            check("incr_pc", int'(pc), k);
        end
        step(0, 0, 0); check("hold_pc", int'(pc), 5);
        step(0, 1, 1); check("clr_wins", int'(pc), 0);

        for (int k = 0; k < 63; k++) step(0, 0, 1);
        check("pc_at_63", int'(pc), 63);
        step(0, 0, 1); check("wrap_pc", int'(pc), 0);

        for (int k = 0; k < 20; k++) step(0, 0, 1);
        check("pc_at_20", int'(pc), 20);
        step(1, 0, 1); check("reset_mid", int'(pc), 0);
        reset = 0; pc_incr = 0;

        dec(8'b00_111_101, 0, -1, 5);
        dec(8'b01_011_000, 1, 3, 0);
        dec(8'b10_100_111, 2, -4, 7);

        alu_op("mul_200_128", 2'b01, 8'd200, 8'd128, 100);
        alu_op("mul_255_255", 2'b01, 8'd255, 8'd255, 254);
        alu_op("mul_0_77",    2'b01, 8'd0,   8'd77,  0);
        alu_op("add_100_50",  2'b00, 8'd100, 8'd50,  150);
        alu_op("add_wrap",    2'b00, 8'd200, 8'd100, 44);
        alu_op("passa",       2'b10, 8'd9,   8'd3,   9);
        alu_op("passb",       2'b11, 8'd9,   8'd3,   3);

        alu_op("filt_mul1", 2'b01, 8'd200, 8'd64, 50);
        p1 = alu_result;
        alu_op("filt_mul2", 2'b01, 8'd40, 8'd192, 30);
        p2 = alu_result;
        alu_op("filt_add", 2'b00, p1, p2, 80);

        for (int k = 0; k < 2000; k++) begin
            instr    = 8'($urandom);
            alu_a    = 8'($urandom);
            alu_b    = 8'($urandom);
            alu_func = 2'($urandom);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), 1'($urandom));
        end

        @(posedge clk);
        #1;
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pico_fetch_exec_units.md
Name: pico_fetch_exec_units

Overview:
- Groups the three leaf units of the picoMIPS filter CPU: the program counter, the instruction decoder and the ALU.
- The CPU control FSM drives `pc_clr`, `pc_incr` and the ALU operands/function.
- Program memory sits between `pc` and `instr`.
- The sample ROM and register file sit around the ALU.
- Only the PC is sequential; the decoder and ALU are purely combinational.

Parameters:
- PC_WIDTH, 6, program counter width (64-word program space).
- I_WIDTH, 8, instruction width.
- DATA_WIDTH, 8, ALU operand/result width (samples, coefficients, accumulator).
- FRAC_BITS, 8, fractional bits of coefficient operand `b` in ALU_MUL.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_clr  in  1  synchronous PC clear (program restart).
- pc_incr  in  1  synchronous PC increment enable.
- pc  out  PC_WIDTH  current program address.
- instr  in  I_WIDTH  instruction word from program memory.
- opcode  out  2  decoded opcode field.
- offset  out  3  signed sample-address offset (two's complement).
- imm  out  3  coefficient index.
- alu_a  in  DATA_WIDTH  operand A (sample or accumulator).
- alu_b  in  DATA_WIDTH  operand B (coefficient or partial product).
- alu_func  in  2  ALU function select.
- alu_result  out  DATA_WIDTH  ALU result.

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-high, port named `reset`.

PC:
- `pc` is the only state. It updates at the rising edge of `clk` with this priority:
  - reset=1 -> pc=0.
  - else pc_clr=1 -> pc=0.
  - else pc_incr=1 -> pc+1.
  - else hold.
- pc_clr and pc_incr asserted together -> pc=0; clear wins.
- Increment from 63 wraps to 0.
- Reset asserted mid-program -> pc=0 on the next edge, regardless of other inputs.
- Reset value of `pc` is 0.
- Decoder and ALU outputs are functions of their inputs only; they have no reset value.

Decoder (combinational, zero latency):
- opcode = instr[7:6].
- offset = instr[5:3], interpreted signed, range -4..+3.
- imm = instr[2:0], unsigned 0..7.
- Opcode encoding: MUL=2'b00, ADD=2'b01, END=2'b10, 2'b11 reserved.
- The decoder forwards the reserved code unchanged; the control FSM treats it as END.

ALU (combinational, zero latency, all operands unsigned):
- ALU_ADD (2'b00): result = (a+b) mod 2^DATA_WIDTH; carry is discarded.
- ALU_MUL (2'b01): full 2*DATA_WIDTH product p = a*b; result = p[FRAC_BITS +: DATA_WIDTH], i.e. b is a Q0.8 fraction.
  - When FRAC_BITS+DATA_WIDTH > 2*DATA_WIDTH, the missing upper bits read as 0.
- ALU_PASSA (2'b10): result = a.
- ALU_PASSB (2'b11): result = b.
- No X propagation on a legal func; all four codes are defined.

Decomposition:
- Package cpu_pkg holds:
  - constants I_WIDTH, OPCODE_WIDTH(=2), IMM_WIDTH(=DATA_WIDTH);
  - opcode localparams MUL/ADD/END;
  - enum aluFunc_t {ALU_ADD, ALU_MUL, ALU_PASSA, ALU_PASSB};
  - coefficient array K[0:7].
- The natural sub-module is `alu`, instantiated once.
- The PC register and the field-slicing decoder stay inline in pico_fetch_exec_units.

Test Plan:
- Reset/PC: reset=1 for 2 cycles, then pc_incr=1 for 5 cycles -> pc=0 during reset, then 1,2,3,4,5.
  - Raise pc_clr and pc_incr together -> pc=0 next edge.
- Wrap: from pc=63 with pc_incr=1 -> pc=0.
  - Reset asserted at pc=20 with pc_incr=1 -> pc=0, not 21.
- Decode:
  - instr=8'b00_111_101 -> opcode=MUL, offset=-1, imm=5.
  - instr=8'b01_011_000 -> opcode=ADD, offset=+3, imm=0.
  - instr=8'b10_100_111 -> opcode=END, offset=-4, imm=7.
- ALU_MUL: a=200, b=128 -> 100. a=255, b=255 -> 254. a=0, b=77 -> 0.
- ALU_ADD: a=100, b=50 -> 150. a=200, b=100 -> 44 (wrap).
  - PASSA: a=9, b=3 -> 9. PASSB: a=9, b=3 -> 3.
- Filter step: two MUL results, 200×64 -> 50 and 40×192 -> 30, then ADD -> 80 on alu_result.
